// File: rtl/jt12_eg_pkg.sv
// Shared definitions for the single-operator and multiplexed envelope generators:
// state encoding, rate pattern table, attenuation limits and sustain-level mapping.
package jt12_eg_pkg;

    localparam int ATT_W = 10;
    localparam logic [ATT_W-1:0] ATT_MAX = 10'h3FF;

    localparam logic [1:0] ST_ATTACK  = 2'd0;
    localparam logic [1:0] ST_DECAY   = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        EG_ATTACK  = ST_ATTACK,
        EG_DECAY   = ST_DECAY,
        EG_SUSTAIN = ST_SUSTAIN,
        EG_RELEASE = ST_RELEASE
    } eg_state_e;

    // Step pattern per eff_rate[1:0]; bit n of a row is the step for idx n.
    localparam logic [3:0][7:0] EG_PATTERN = {8'hFE, 8'hEE, 8'hBA, 8'hAA};

    // Sustain level in attenuation units; the top code jumps to near-silence.
    function automatic logic [ATT_W-1:0] sl_level(input logic [3:0] sl);
        return (sl == 4'hF) ? 10'h3E0 : {1'b0, sl, 5'b0};
    endfunction

endpackage

// File: rtl/jt12_eg_single_if.sv
// Operator-side bundle of the envelope generator: strobes, rates and results.
interface jt12_eg_single_if;
    import jt12_eg_pkg::*;

    logic             clk_en;
    logic             cnt_upd;
    logic [14:0]      eg_cnt;
    logic             keyon;
    logic [4:0]       ar;
    logic [4:0]       d1r;
    logic [4:0]       d2r;
    logic [3:0]       rr;
    logic [3:0]       sl;
    logic [4:0]       keycode;
    logic [1:0]       ks;
    logic [6:0]       tl;
    logic [1:0]       state;
    logic [ATT_W-1:0] att;
    logic [ATT_W-1:0] eg_out;

    modport master (
        output clk_en, cnt_upd, eg_cnt, keyon, ar, d1r, d2r, rr, sl, keycode, ks, tl,
        input  state, att, eg_out
    );

    modport slave (
        input  clk_en, cnt_upd, eg_cnt, keyon, ar, d1r, d2r, rr, sl, keycode, ks, tl,
        output state, att, eg_out
    );

endinterface

// File: rtl/jt12_eg_rate_sel.sv
// Effective rate from the selected rate and key scaling, and the per-update
// attenuation increment picked from the global envelope counter.
module jt12_eg_rate_sel
    import jt12_eg_pkg::*;
(
    input  logic [4:0]  rate,
    input  logic [4:0]  keycode,
    input  logic [1:0]  ks,
    input  logic [14:0] eg_cnt,
    output logic [5:0]  eff_rate,
    output logic [3:0]  inc
);

    logic [4:0]  ksv;
    logic [6:0]  rate_sum;
    logic [3:0]  shift;
    logic [14:0] low_mask;
    logic        step;
    logic [2:0]  idx_lo;
    logic        pat_lo;
    logic        pat_hi;

    // Key-scaled rate, saturated at 63; a zero rate stays frozen.
    always_comb begin
        ksv      = keycode >> (2'd3 - ks);
        rate_sum = {1'b0, rate, 1'b0} + {2'b0, ksv};
        if (rate == 5'd0)
            eff_rate = 6'd0;
        else if (rate_sum > 7'd63)
            eff_rate = 6'd63;
        else
            eff_rate = rate_sum[5:0];
    end

    // Increment selection: slow rates step on counter boundaries, fast rates every update.
    // NOTE: every signal written here gets a value on entry, so no path can infer a latch.
    always_comb begin
        shift    = 4'd11 - eff_rate[5:2];
        low_mask = (15'd1 << shift) - 15'd1;
        step     = (eg_cnt & low_mask) == 15'd0;
        idx_lo   = 3'(eg_cnt >> shift);
        pat_lo   = EG_PATTERN[eff_rate[1:0]][idx_lo];
        pat_hi   = EG_PATTERN[eff_rate[1:0]][eg_cnt[2:0]];
        inc      = 4'd0;
        if (eff_rate < 6'd2)
            inc = 4'd0;
        else if (eff_rate < 6'd48)
            inc = (step && pat_lo) ? 4'd1 : 4'd0;
        else if (eff_rate < 6'd60)
            inc = (pat_hi ? 4'd2 : 4'd1) << eff_rate[3:2];
        else
            inc = 4'd8;
    end

endmodule

// File: rtl/jt12_eg_single.sv
// Single-operator ADSR envelope generator with total-level output stage.
module jt12_eg_single
    import jt12_eg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    jt12_eg_single_if.slave  eg
);

    eg_state_e        state_q;
    logic [ATT_W-1:0] att_q;
    logic [ATT_W-1:0] eg_out_q;
    logic             keyon_l;

    logic             key_rise;
    logic             key_fall;
    logic [4:0]       rate_cur;
    logic [5:0]       eff_rate;
    logic [3:0]       inc;
    logic [10:0]      att_sum;
    logic [ATT_W-1:0] att_up;
    logic [14:0]      atk_num;
    logic [10:0]      atk_dec;
    logic [ATT_W-1:0] att_dn;
    logic [10:0]      out_sum;
    logic [ATT_W-1:0] out_sat;

    // Key edges and the rate feeding the selector; a rising edge previews the attack rate.
    always_comb begin
        key_rise = eg.keyon & ~keyon_l;
        key_fall = ~eg.keyon & keyon_l;
        rate_cur = eg.ar;
        if (!key_rise) begin
            case (state_q)
                EG_ATTACK:  rate_cur = eg.ar;
                EG_DECAY:   rate_cur = eg.d1r;
                EG_SUSTAIN: rate_cur = eg.d2r;
                default:    rate_cur = {eg.rr, 1'b1};
            endcase
        end
    end

    jt12_eg_rate_sel u_rate_sel (
        .rate     (rate_cur),
        .keycode  (eg.keycode),
        .ks       (eg.ks),
        .eg_cnt   (eg.eg_cnt),
        .eff_rate (eff_rate),
        .inc      (inc)
    );

    // Saturating attenuation arithmetic, done wide enough that nothing wraps.
    always_comb begin
        att_sum = {1'b0, att_q} + {7'b0, inc};
        att_up  = (att_sum > {1'b0, ATT_MAX}) ? ATT_MAX : att_sum[ATT_W-1:0];
        atk_num = ({5'b0, att_q} + 15'd1) * {11'b0, inc} + 15'd15;
        atk_dec = atk_num[14:4];
        att_dn  = (atk_dec > {1'b0, att_q}) ? '0 : 10'({1'b0, att_q} - atk_dec);
        out_sum = {1'b0, att_q} + {1'b0, eg.tl, 3'b0};
        out_sat = (out_sum > {1'b0, ATT_MAX}) ? ATT_MAX : out_sum[ATT_W-1:0];
    end

    // Envelope state machine, attenuation register and registered total-level output.
    // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EG_RELEASE;
            att_q    <= ATT_MAX;
            eg_out_q <= ATT_MAX;
            keyon_l  <= 1'b0;
        end else if (eg.clk_en) begin
            keyon_l  <= eg.keyon;
            eg_out_q <= out_sat;
            if (key_rise) begin
                state_q <= EG_ATTACK;
                if (eff_rate >= 6'd62)
                    att_q <= '0;
            end else if (key_fall) begin
                state_q <= EG_RELEASE;
            end else if (eg.cnt_upd) begin
                case (state_q)
                    EG_ATTACK: begin
                        if (att_q == '0)
                            state_q <= EG_DECAY;
                        else if (inc != 4'd0 && eff_rate < 6'd62)
                            att_q <= att_dn;
                    end
                    EG_DECAY: begin
                        att_q <= att_up;
                        if (att_q >= sl_level(eg.sl))
                            state_q <= EG_SUSTAIN;
                    end
                    default: att_q <= att_up;
                endcase
            end
        end
    end

    assign eg.state  = state_q;
    assign eg.att    = att_q;
    assign eg.eg_out = eg_out_q;

endmodule
